apb_gpio_debounce_in: RTL and testbench
=======================================

# apb_gpio_debounce_in

APB3 slave providing a parametrised bank of debounced general-purpose inputs with per-bit rising/falling-edge interrupt capture. It is the successor to the fixed 2-input GPIO-in instance on the peripheral APB bus and serves push-buttons and switches on the Creative Board. Each input is synchronised, debounced by a software-programmable cycle count, and edge-detected into a write-1-to-clear status register driving per-bit and ORed interrupt lines to the MiV core.

## Interface
- IO_NUM, 2, number of inputs, 1..32
- DEB_W, 16, debounce counter / limit width, 1..24
- DEB_RESET, 1000, reset value of DEB_LIMIT, < 2^DEB_W

- PCLK  in  1  clock; all logic on rising edge
- PRESETN  in  1  reset, asynchronous, active-low
- PSEL, PENABLE, PWRITE  in  1 each  APB3 control
- PADDR  in  8  byte address; bits [1:0] ignored
- PWDATA  in  32  write data
- PRDATA  out  32  read data
- PREADY  out  1  tied 1, no wait states
- PSLVERR  out  1  error for unmapped address
- GPIO_IN  in  IO_NUM  asynchronous pins
- INT  out  IO_NUM  per-bit interrupt, equal to INT_STAT
- INT_OR  out  1  OR of INT

## Operation
- Register map, word offsets: 0x00 DATA (RO, debounced value); 0x04 RAW (RO, synchronised value); 0x08 RISE_EN (RW); 0x0C FALL_EN (RW); 0x10 INT_STAT (read, W1C); 0x14 DEB_LIMIT (RW, DEB_W bits).
- Bits above IO_NUM (above DEB_W for DEB_LIMIT) read 0, writes ignored. Writes to RO registers are ignored, PSLVERR=0.
- Unmapped offset (0x18..0xFC): PRDATA=0; PSLVERR=1 during the access phase (PSEL&PENABLE); writes have no effect.
- Write commits on the PCLK edge with PSEL&PENABLE&PWRITE. PRDATA is combinational from PADDR while PSEL=1, and 0 otherwise.
- Per bit: 2-flop synchroniser → sync. Counter cnt increments while sync≠deb and clears while sync==deb.
- When a mismatch cycle sees cnt ≥ max(DEB_LIMIT,1)−1, deb takes the value of sync and cnt clears. DEB_LIMIT=0 behaves as 1.
- cnt saturates at all-ones. Lowering DEB_LIMIT mid-count takes effect on the next mismatch cycle.
- INT_STAT[i] sets on the same edge that deb[i] rises with RISE_EN[i]=1, or falls with FALL_EN[i]=1.
- W1C clears the written-1 bits. A set in the same cycle as a clear wins: bit stays 1.
- Changing RISE_EN/FALL_EN never sets or clears existing status.

## Timing
- Reset: PRDATA=0, PSLVERR=0, PREADY=1, INT=0, INT_OR=0. sync, deb, cnt, RISE_EN, FALL_EN, INT_STAT are 0; DEB_LIMIT=DEB_RESET.
- Pin to RAW: 2 cycles. Pin to DATA/INT: 2+max(L,1) cycles for a stable level, where L=DEB_LIMIT.
- A glitch shorter than L cycles at sync never changes deb.
- INT and INT_OR are registered. INT_OR follows INT in the same cycle, with no extra stage.
- A pin high at reset release changes deb after 2+L cycles. No interrupt results, since enables reset to 0.
- Reset asserted mid-count returns all state to reset values immediately.

## Structure
- Package apb_gpio_in_pkg: register offset constants (DATA_OFS..DEB_LIMIT_OFS) and the register count.
- Sub-module gpio_debounce_bit holds the synchroniser, counter and deb flop. It is instantiated IO_NUM times in a generate loop and takes limit, with outputs sync, deb, rise, fall.
- The top level holds the APB decode, the RW registers and INT_STAT.

## Test plan
- Reset with GPIO_IN=2'b11 → all outputs at reset values; after DEB_RESET+2 cycles DATA=0x3, INT=0.
- Set DEB_LIMIT=4 and RISE_EN=0x1. A 3-cycle pulse on GPIO_IN[0] gives DATA unchanged and INT=0. A 6-cycle pulse gives DATA[0]=1 exactly 6 cycles after the pin edge, with INT[0]=1 and INT_OR=1.
- FALL_EN=0x2 with a bit1 high→low → INT_STAT=0x2. Write 0x2 to 0x10 → INT_STAT=0. Write 0x1 → no change.
- Bit 0 rising edge coincides with a W1C of 0x1 → INT_STAT[0] remains 1.
- DEB_LIMIT=0 → DATA follows the pin after 3 cycles.
- Write then read RISE_EN with 0xFFFFFFFF at IO_NUM=2 → reads 0x3. Read 0x20 → PRDATA=0 and PSLVERR=1. Write DATA → no effect, PSLVERR=0.

Source files
------------

// File: rtl/apb_gpio_debounce_in_pkg.sv
// Shared constants for the debounced APB GPIO input bank: bus widths and register map.
package apb_gpio_in_pkg;

  localparam int unsigned APB_AW = 8;
  localparam int unsigned APB_DW = 32;

  // Byte offsets of the mapped registers (word aligned)
  localparam logic [APB_AW-1:0] DATA_OFS      = 8'h00;
  localparam logic [APB_AW-1:0] RAW_OFS       = 8'h04;
  localparam logic [APB_AW-1:0] RISE_EN_OFS   = 8'h08;
  localparam logic [APB_AW-1:0] FALL_EN_OFS   = 8'h0C;
  localparam logic [APB_AW-1:0] INT_STAT_OFS  = 8'h10;
  localparam logic [APB_AW-1:0] DEB_LIMIT_OFS = 8'h14;

  localparam int unsigned REG_NUM = 6;

  // Word-aligned form of a byte address; the two low bits carry no meaning.
  function automatic logic [APB_AW-1:0] word_addr(input logic [APB_AW-1:0] addr);
    return {addr[APB_AW-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/apb_gpio_debounce_in_if.sv
// APB3 signal bundle between the peripheral bus master and the GPIO input slave.
interface apb_gpio_debounce_in_if;
  import apb_gpio_in_pkg::*;

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [APB_AW-1:0] PADDR;
  logic [APB_DW-1:0] PWDATA;
  logic [APB_DW-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_gpio_debounce_in_bit.sv
// One input channel: 2-flop synchroniser, mismatch counter and debounced flop.
// rise/fall are same-cycle strobes for the edge on which deb is about to change.
module gpio_debounce_bit #(
  parameter int unsigned DEB_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pin,
  input  logic [DEB_W-1:0] limit,
  output logic             sync,
  output logic             deb,
  output logic             rise,
  output logic             fall
);

  logic             meta;
  logic [DEB_W-1:0] cnt;
  logic [DEB_W-1:0] lim_m1;
  logic             mismatch;
  logic             settle;

  // A limit of zero is treated as one: settle on the first mismatch cycle
  always_comb begin
    lim_m1   = (limit == '0) ? '0 : limit - DEB_W'(1);
    mismatch = sync ^ deb;
    settle   = mismatch && (cnt >= lim_m1);
    rise     = settle & sync;
    fall     = settle & ~sync;
  end

  // Synchroniser, saturating mismatch counter and debounced value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      deb  <= 1'b0;
      cnt  <= '0;
    end else begin
      meta <= pin;
      sync <= meta;
      if (!mismatch) begin
        cnt <= '0;
      end else if (settle) begin
        deb <= sync;
        cnt <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + DEB_W'(1);
      end
    end
  end

endmodule

// File: rtl/apb_gpio_debounce_in.sv
// APB3 slave: bank of debounced inputs with rise/fall edge capture into a
// write-1-to-clear status register that drives the interrupt lines.
module apb_gpio_debounce_in
  import apb_gpio_in_pkg::*;
#(
  parameter int unsigned IO_NUM    = 2,
  parameter int unsigned DEB_W     = 16,
  parameter int unsigned DEB_RESET = 1000
) (
  input  logic                PCLK,
  input  logic                PRESETN,
  apb_gpio_debounce_in_if.slave apb,
  input  logic [IO_NUM-1:0]   GPIO_IN,
  output logic [IO_NUM-1:0]   INT,
  output logic                INT_OR
);

  logic [IO_NUM-1:0] raw;
  logic [IO_NUM-1:0] deb;
  logic [IO_NUM-1:0] deb_rise;
  logic [IO_NUM-1:0] deb_fall;
  logic [IO_NUM-1:0] rise_en;
  logic [IO_NUM-1:0] fall_en;
  logic [IO_NUM-1:0] int_stat;
  logic [IO_NUM-1:0] int_stat_nxt;
  logic [IO_NUM-1:0] w1c;
  logic [DEB_W-1:0]  deb_limit;

  logic [APB_AW-1:0] waddr;
  logic [APB_DW-1:0] rdata;
  logic              mapped;
  logic              wr_en;
  logic              wr_rise;
  logic              wr_fall;
  logic              wr_stat;
  logic              wr_limit;
  logic              unused_bits;

  // Per-input synchroniser and debouncer
  for (genvar i = 0; i < IO_NUM; i++) begin : g_bit
    gpio_debounce_bit #(.DEB_W(DEB_W)) u_bit (
      .clk   (PCLK),
      .rst_n (PRESETN),
      .pin   (GPIO_IN[i]),
      .limit (deb_limit),
      .sync  (raw[i]),
      .deb   (deb[i]),
      .rise  (deb_rise[i]),
      .fall  (deb_fall[i])
    );
  end

  assign waddr       = word_addr(apb.PADDR);
  assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA};

  // Read mux and address map decode
  always_comb begin
    rdata  = '0;
    mapped = 1'b1;
    case (waddr)
      DATA_OFS:      rdata = APB_DW'(deb);
      RAW_OFS:       rdata = APB_DW'(raw);
      RISE_EN_OFS:   rdata = APB_DW'(rise_en);
      FALL_EN_OFS:   rdata = APB_DW'(fall_en);
      INT_STAT_OFS:  rdata = APB_DW'(int_stat);
      DEB_LIMIT_OFS: rdata = APB_DW'(deb_limit);
      default:       mapped = 1'b0;
    endcase
  end

  assign apb.PRDATA  = apb.PSEL ? rdata : '0;
  assign apb.PSLVERR = apb.PSEL & apb.PENABLE & ~mapped;
  assign apb.PREADY  = 1'b1;

  // Write strobes for the writable registers
  always_comb begin
    wr_en    = apb.PSEL & apb.PENABLE & apb.PWRITE;
    wr_rise  = wr_en && (waddr == RISE_EN_OFS);
    wr_fall  = wr_en && (waddr == FALL_EN_OFS);
    wr_stat  = wr_en && (waddr == INT_STAT_OFS);
    wr_limit = wr_en && (waddr == DEB_LIMIT_OFS);
  end

  // Status update: clear written ones, then new edges win over the clear
  always_comb begin
    w1c          = wr_stat ? apb.PWDATA[IO_NUM-1:0] : '0;
    int_stat_nxt = (int_stat & ~w1c) | (deb_rise & rise_en) | (deb_fall & fall_en);
  end

  // Control registers, status and registered interrupt outputs
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      rise_en   <= '0;
      fall_en   <= '0;
      deb_limit <= DEB_W'(DEB_RESET);
      int_stat  <= '0;
      INT_OR    <= 1'b0;
    end else begin
      if (wr_rise)  rise_en   <= apb.PWDATA[IO_NUM-1:0];
      if (wr_fall)  fall_en   <= apb.PWDATA[IO_NUM-1:0];
      if (wr_limit) deb_limit <= apb.PWDATA[DEB_W-1:0];
      int_stat <= int_stat_nxt;
      INT_OR   <= |int_stat_nxt;
    end
  end

  assign INT = int_stat;

endmodule

// File: tb/tb_apb_gpio_debounce_in.sv
// Bench for apb_gpio_debounce_in: directed scenarios with literal expectations
// followed by randomized pins and bus traffic against a behavioural model.
module tb_apb_gpio_debounce_in;
  import apb_gpio_in_pkg::*;

  localparam int unsigned IO_NUM    = 2;
  localparam int unsigned DEB_W     = 16;
  localparam int unsigned DEB_RESET = 1000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [IO_NUM-1:0] gpio;
  logic [IO_NUM-1:0] int_v;
  logic              int_or;

  apb_gpio_debounce_in_if bus ();

  apb_gpio_debounce_in #(
    .IO_NUM    (IO_NUM),
    .DEB_W     (DEB_W),
    .DEB_RESET (DEB_RESET)
  ) dut (
    .PCLK    (clk),
    .PRESETN (rst_n),
    .apb     (bus),
    .GPIO_IN (gpio),
    .INT     (int_v),
    .INT_OR  (int_or)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A pin level reaches RAW two edges later. A bit's debounced value takes RAW
  // once RAW has disagreed with it for max(limit,1) consecutive cycles.
  logic [IO_NUM-1:0] m_meta, m_sync, m_deb, m_rise_en, m_fall_en, m_stat;
  logic [IO_NUM-1:0] m_set, m_clr;
  int                m_run [IO_NUM];
  int                m_lim;
  int                m_leff;
  logic              m_wr;
  logic [7:0]        m_wa;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_meta    = '0;
      m_sync    = '0;
      m_deb     = '0;
      m_rise_en = '0;
      m_fall_en = '0;
      m_stat    = '0;
      m_lim     = int'(DEB_RESET);
      for (int i = 0; i < IO_NUM; i++) m_run[i] = 0;
    end else begin
      m_wr   = bus.PSEL && bus.PENABLE && bus.PWRITE;
      m_wa   = {bus.PADDR[7:2], 2'b00};
      m_leff = (m_lim == 0) ? 1 : m_lim;
      m_set  = '0;
      for (int i = 0; i < IO_NUM; i++) begin
        if (m_sync[i] != m_deb[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] >= m_leff) begin
            m_deb[i] = m_sync[i];
            m_run[i] = 0;
            if (m_deb[i] ? m_rise_en[i] : m_fall_en[i]) m_set[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
        m_sync[i] = m_meta[i];
        m_meta[i] = gpio[i];
      end
      m_clr  = (m_wr && m_wa == 8'h10) ? bus.PWDATA[IO_NUM-1:0] : '0;
      m_stat = (m_stat & ~m_clr) | m_set;
      if (m_wr) begin
        case (m_wa)
          8'h08:   m_rise_en = bus.PWDATA[IO_NUM-1:0];
          8'h0C:   m_fall_en = bus.PWDATA[IO_NUM-1:0];
          8'h14:   m_lim     = int'(bus.PWDATA[DEB_W-1:0]);
          default: ;
        endcase
      end
    end
  end

  function automatic logic [31:0] exp_rd(input logic [7:0] a);
    case ({a[7:2], 2'b00})
      8'h00:   return 32'(m_deb);
      8'h04:   return 32'(m_sync);
      8'h08:   return 32'(m_rise_en);
      8'h0C:   return 32'(m_fall_en);
      8'h10:   return 32'(m_stat);
      8'h14:   return 32'(m_lim);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic is_mapped(input logic [7:0] a);
    return a[7:2] < 6'd6;
  endfunction

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    check("int", 32'(int_v), 32'(m_stat));
    check("int_or", 32'(int_or), 32'(|m_stat));
    check("pready", 32'(bus.PREADY), 32'd1);
    check("prdata", bus.PRDATA, bus.PSEL ? exp_rd(bus.PADDR) : 32'd0);
    check("pslverr", 32'(bus.PSLVERR),
          32'(bus.PSEL && bus.PENABLE && !is_mapped(bus.PADDR)));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = DATA_OFS;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic exp_err);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = a;
    bus.PWDATA  = d;
    tick(1);
    bus.PENABLE = 1'b1;
    #1;
    check("wr_pslverr", 32'(bus.PSLVERR), 32'(exp_err));
    tick(1);
    idle();
  endtask

  task automatic chk_rd(input string name, input logic [7:0] a, input logic [31:0] exp);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = a;
    #1;
    check(name, bus.PRDATA, exp);
    idle();
  endtask

  task automatic rd_acc(input logic [7:0] a, input logic [31:0] exp_d, input logic exp_err);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = a;
    tick(1);
    bus.PENABLE = 1'b1;
    #1;
    check("acc_prdata", bus.PRDATA, exp_d);
    check("acc_pslverr", 32'(bus.PSLVERR), 32'(exp_err));
    tick(1);
    idle();
  endtask

  int hold [IO_NUM];
  int phase;
  int r;

  initial begin
    rst_n       = 1'b0;
    gpio        = 2'b11;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = '0;
    bus.PWDATA  = '0;
    tick(3);

    // Reset values with both pins high
    check("rst_prdata", bus.PRDATA, 32'd0);
    check("rst_pslverr", 32'(bus.PSLVERR), 32'd0);
    check("rst_pready", 32'(bus.PREADY), 32'd1);
    check("rst_int", 32'(int_v), 32'd0);
    check("rst_int_or", 32'(int_or), 32'd0);
    rst_n = 1'b1;
    idle();
    tick(DEB_RESET + 1);
    chk_rd("data_before_settle", DATA_OFS, 32'h0);
    tick(1);
    chk_rd("data_after_settle", DATA_OFS, 32'h3);
    check("int_after_settle", 32'(int_v), 32'd0);

    // Short glitch is filtered, long pulse settles after 2+L cycles
    wr(DEB_LIMIT_OFS, 32'd4, 1'b0);
    gpio = 2'b00;
    tick(10);
    wr(RISE_EN_OFS, 32'h1, 1'b0);
    tick(2);
    gpio[0] = 1'b1;
    tick(3);
    gpio[0] = 1'b0;
    tick(10);
    chk_rd("glitch_data", DATA_OFS, 32'h0);
    check("glitch_int", 32'(int_v), 32'd0);
    gpio[0] = 1'b1;
    tick(5);
    chk_rd("pulse_data_early", DATA_OFS, 32'h0);
    tick(1);
    chk_rd("pulse_data", DATA_OFS, 32'h1);
    check("pulse_int", 32'(int_v), 32'h1);
    check("pulse_int_or", 32'(int_or), 32'd1);
    gpio[0] = 1'b0;
    tick(10);

    // Falling-edge capture and write-1-to-clear
    wr(FALL_EN_OFS, 32'h2, 1'b0);
    wr(INT_STAT_OFS, 32'h1, 1'b0);
    chk_rd("stat_cleared0", INT_STAT_OFS, 32'h0);
    gpio[1] = 1'b1;
    tick(10);
    gpio[1] = 1'b0;
    tick(10);
    chk_rd("fall_stat", INT_STAT_OFS, 32'h2);
    check("fall_int", 32'(int_v), 32'h2);
    wr(INT_STAT_OFS, 32'h1, 1'b0);
    chk_rd("w1c_other_bit", INT_STAT_OFS, 32'h2);
    wr(INT_STAT_OFS, 32'h2, 1'b0);
    chk_rd("w1c_clear", INT_STAT_OFS, 32'h0);

    // Edge on the same cycle as its clear keeps the bit set
    gpio[0] = 1'b1;
    tick(4);
    wr(INT_STAT_OFS, 32'h1, 1'b0);
    chk_rd("set_beats_clear", INT_STAT_OFS, 32'h1);
    wr(INT_STAT_OFS, 32'h1, 1'b0);
    chk_rd("stat_clear_again", INT_STAT_OFS, 32'h0);

    // Limit of zero behaves as one
    wr(DEB_LIMIT_OFS, 32'd0, 1'b0);
    gpio[0] = 1'b0;
    tick(2);
    chk_rd("lim0_early", DATA_OFS, 32'h1);
    tick(1);
    chk_rd("lim0_data", DATA_OFS, 32'h0);

    // Width masking, unmapped access and read-only writes
    wr(RISE_EN_OFS, 32'hFFFF_FFFF, 1'b0);
    chk_rd("rise_en_mask", RISE_EN_OFS, 32'h3);
    chk_rd("enable_no_set", INT_STAT_OFS, 32'h0);
    rd_acc(8'h20, 32'h0, 1'b1);
    wr(DATA_OFS, 32'h5, 1'b0);
    chk_rd("data_ro", DATA_OFS, 32'h0);
    chk_rd("limit_rd", DEB_LIMIT_OFS, 32'h0);
    wr(8'h40, 32'hFFFF_FFFF, 1'b1);
    chk_rd("limit_after_unmapped_wr", DEB_LIMIT_OFS, 32'h0);

    // Randomized pins and bus traffic
    for (int i = 0; i < IO_NUM; i++) hold[i] = 0;
    phase = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc == 2000) begin
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        rst_n       = 1'b0;
        tick(2);
        rst_n = 1'b1;
        wr(DEB_LIMIT_OFS, 32'd3, 1'b0);
      end
      for (int i = 0; i < IO_NUM; i++) begin
        if (hold[i] == 0) begin
          gpio[i] = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 10);
        end else begin
          hold[i] = hold[i] - 1;
        end
      end
      if (phase == 1) begin
        bus.PENABLE = 1'b1;
        phase       = 0;
      end else if ($urandom_range(0, 5) == 0) begin
        r           = $urandom_range(0, 7);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'($urandom_range(0, 1));
        bus.PADDR   = (r < 6) ? 8'(r * 4 + $urandom_range(0, 3))
                              : 8'($urandom_range(6, 63) * 4 + $urandom_range(0, 3));
        bus.PWDATA  = ({bus.PADDR[7:2], 2'b00} == DEB_LIMIT_OFS) ? 32'($urandom_range(0, 7))
                                                                 : 32'($urandom);
        phase       = 1;
      end else begin
        bus.PSEL    = 1'($urandom_range(0, 3) != 0);
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = 8'($urandom_range(0, 255));
      end
      tick(1);
    end

    idle();
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
